// File: rtl/ara_apb_arb_pkg.sv
// Shared types for the APB round-robin arbiter: FSM states, latched request
// record and default timeout.
package ara_apb_arb_pkg;

  localparam int unsigned ArbAddrWidth      = 32;
  localparam int unsigned ArbDataWidth      = 32;
  localparam int unsigned ArbDefaultTimeout = 256;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } apb_arb_state_e;

  // Widest supported request; narrower parameterisations use the low bits.
  typedef struct packed {
    logic                    write;
    logic [ArbAddrWidth-1:0] addr;
    logic [ArbDataWidth-1:0] wdata;
  } apb_arb_req_t;

endpackage

// File: rtl/ara_apb_rr_arbiter.sv
// Combinational round-robin pick: first valid requester above ptr_i, wrapping,
// so the most recently served requester ends up last in line.
module ara_apb_rr_arbiter #(
  parameter int unsigned NrReq = 2,
  parameter int unsigned IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic [NrReq-1:0] valid_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [NrReq-1:0] grant_o,
  output logic [IdxW-1:0]  idx_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 1; off <= int'(NrReq); off++) begin
      cand = IdxW'((int'(ptr_i) + off) % int'(NrReq));
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/ara_apb_arbiter.sv
// Shares one APB slave port between NrReq valid/ready requesters with
// round-robin grants. Optional ACCESS timeout: define ARA_APB_ARB_TIMEOUT_EN.
module ara_apb_arbiter
  import ara_apb_arb_pkg::*;
#(
  parameter int unsigned NrReq         = 2,
  parameter int unsigned AddrWidth     = ArbAddrWidth,
  parameter int unsigned DataWidth     = ArbDataWidth,
  parameter int unsigned TimeoutCycles = ArbDefaultTimeout
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NrReq-1:0]           req_valid_i,
  output logic [NrReq-1:0]           req_ready_o,
  input  logic [NrReq-1:0]           req_write_i,
  input  logic [NrReq*AddrWidth-1:0] req_addr_i,
  input  logic [NrReq*DataWidth-1:0] req_wdata_i,
  output logic [NrReq-1:0]           rsp_valid_o,
  output logic [DataWidth-1:0]       rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic                       apb_psel_o,
  output logic                       apb_penable_o,
  output logic                       apb_pwrite_o,
  output logic [AddrWidth-1:0]       apb_paddr_o,
  output logic [DataWidth-1:0]       apb_pwdata_o,
  input  logic [DataWidth-1:0]       apb_prdata_i,
  input  logic                       apb_pready_i,
  input  logic                       apb_pslverr_i
);

  localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;

  if (NrReq < 1 || TimeoutCycles < 1 ||
      AddrWidth > ArbAddrWidth || DataWidth > ArbDataWidth) begin : gen_param_check
    $error("ara_apb_arbiter: unsupported parameter combination");
  end

  apb_arb_state_e       state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [IdxW-1:0]      gnt_q, gnt_d;
  apb_arb_req_t         req_q, req_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [NrReq-1:0]     grantOh;
  logic [IdxW-1:0]      grantIdx;
  logic                 inTransfer;

`ifdef ARA_APB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  ara_apb_rr_arbiter #(
    .NrReq (NrReq),
    .IdxW  (IdxW)
  ) u_rr (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grantOh),
    .idx_o   (grantIdx)
  );

  // Ready is masked during reset so nobody believes a request was taken
  // while the state register is held.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    req_d       = req_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
`ifdef ARA_APB_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (|req_valid_i) begin
          if (!rst_i) req_ready_o = grantOh;
          gnt_d       = grantIdx;
          req_d.write = req_write_i[grantIdx];
          req_d.addr  = ArbAddrWidth'(req_addr_i[int'(grantIdx)*AddrWidth +: AddrWidth]);
          req_d.wdata = ArbDataWidth'(req_wdata_i[int'(grantIdx)*DataWidth +: DataWidth]);
          state_d     = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
`ifdef ARA_APB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StAccess: begin
        if (apb_pready_i) begin
          rdata_d = req_q.write ? '0 : apb_prdata_i;
          err_d   = apb_pslverr_i;
          state_d = StResp;
        end
`ifdef ARA_APB_ARB_TIMEOUT_EN
        // A pready in the final allowed cycle still completes normally.
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StResp: begin
        rsp_valid_o[gnt_q] = 1'b1;
        ptr_d              = gnt_q;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= IdxW'(NrReq - 1);
      gnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef ARA_APB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef ARA_APB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign inTransfer    = (state_q == StSetup) || (state_q == StAccess);
  assign apb_psel_o    = inTransfer;
  assign apb_penable_o = (state_q == StAccess);
  assign apb_pwrite_o  = inTransfer & req_q.write;
  assign apb_paddr_o   = inTransfer ? AddrWidth'(req_q.addr) : '0;
  assign apb_pwdata_o  = inTransfer ? DataWidth'(req_q.wdata) : '0;
  assign rsp_rdata_o   = (state_q == StResp) ? rdata_q : '0;
  assign rsp_err_o     = (state_q == StResp) & err_q;

endmodule

// File: tb/tb_ara_apb_arbiter.sv
// Self-checking bench for ara_apb_arbiter: directed vector table, corner-case
// sequences and a randomized run against a cycle-count reference model.
module tb_ara_apb_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    reqValid, reqReady, reqWrite, rspValid;
  logic [NR*AW-1:0] reqAddr;
  logic [NR*DW-1:0] reqWdata;
  logic [DW-1:0]    rspRdata, prdata, pwdata;
  logic [AW-1:0]    paddr;
  logic rspErr, psel, penable, pwrite, pready, pslverr;

  logic oneValid, oneReady, oneWrite, oneRsp, oneErr, onePsel, onePen, onePwrite;
  logic [AW-1:0] oneAddr, onePaddr;
  logic [DW-1:0] oneWdata, oneRdata, onePwdata;

  int testsRun = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ara_apb_arbiter #(.NrReq(NR), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_write_i(reqWrite),
    .req_addr_i(reqAddr), .req_wdata_i(reqWdata),
    .rsp_valid_o(rspValid), .rsp_rdata_o(rspRdata), .rsp_err_o(rspErr),
    .apb_psel_o(psel), .apb_penable_o(penable), .apb_pwrite_o(pwrite),
    .apb_paddr_o(paddr), .apb_pwdata_o(pwdata), .apb_prdata_i(prdata),
    .apb_pready_i(pready), .apb_pslverr_i(pslverr)
  );

  // Single-requester instance with an always-ready slave.
  ara_apb_arbiter #(.NrReq(1), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)) u_one (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(oneValid), .req_ready_o(oneReady), .req_write_i(oneWrite),
    .req_addr_i(oneAddr), .req_wdata_i(oneWdata),
    .rsp_valid_o(oneRsp), .rsp_rdata_o(oneRdata), .rsp_err_o(oneErr),
    .apb_psel_o(onePsel), .apb_penable_o(onePen), .apb_pwrite_o(onePwrite),
    .apb_paddr_o(onePaddr), .apb_pwdata_o(onePwdata), .apb_prdata_i(32'hA5A5_0001),
    .apb_pready_i(1'b1), .apb_pslverr_i(1'b0)
  );

  typedef struct {
    int          req;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    bit          slverr;
    logic [31:0] expRdata;
    bit          expErr;
  } vec_t;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ready"},   reqReady, 0);
    checkOutput({tag, " rspValid"}, rspValid, 0);
    checkOutput({tag, " rdata"},   rspRdata, 0);
    checkOutput({tag, " err"},     rspErr, 0);
    checkOutput({tag, " psel"},    psel, 0);
    checkOutput({tag, " penable"}, penable, 0);
    checkOutput({tag, " pwrite"},  pwrite, 0);
    checkOutput({tag, " paddr"},   paddr, 0);
    checkOutput({tag, " pwdata"},  pwdata, 0);
  endtask

  task automatic clearInputs();
    reqValid = '0; reqWrite = '0; reqAddr = '0; reqWdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    oneValid = 1'b0; oneWrite = 1'b0; oneAddr = '0; oneWdata = '0;
  endtask

  task automatic doReset();
    tick();
    rst = 1'b1;
    clearInputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One complete transfer from an idle arbiter, checked cycle by cycle.
  task automatic applyStimulus(input vec_t v);
    logic [NR-1:0] expOh;
    expOh = '0;
    expOh[v.req] = 1'b1;
    tick();
    reqValid = expOh;
    reqWrite[v.req] = v.write;
    reqAddr[v.req*AW +: AW] = v.addr;
    reqWdata[v.req*DW +: DW] = v.wdata;
    pready = 1'b0;
    #1;
    checkOutput("accept ready", reqReady, expOh);
    checkOutput("accept psel", psel, 0);
    tick();
    reqValid = '0;
    reqAddr = {$urandom, $urandom};
    reqWdata = {$urandom, $urandom};
    reqWrite = NR'($urandom);
    #1;
    checkOutput("setup psel", psel, 1);
    checkOutput("setup penable", penable, 0);
    checkOutput("setup paddr", paddr, v.addr);
    checkOutput("setup pwrite", pwrite, v.write);
    checkOutput("setup pwdata", pwdata, v.wdata);
    for (int a = 0; a <= v.waits; a++) begin
      tick();
      pready  = (a == v.waits);
      prdata  = pready ? v.prdata : $urandom;
      pslverr = pready ? v.slverr : 1'($urandom);
      #1;
      checkOutput("access psel", psel, 1);
      checkOutput("access penable", penable, 1);
      checkOutput("access paddr", paddr, v.addr);
      checkOutput("access pwdata", pwdata, v.wdata);
    end
    tick();
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    #1;
    checkOutput("resp valid", rspValid, expOh);
    checkOutput("resp rdata", rspRdata, v.expRdata);
    checkOutput("resp err", rspErr, v.expErr);
    checkOutput("resp psel", psel, 0);
    checkOutput("resp paddr", paddr, 0);
    tick();
    pready = 1'b0;
    #1;
    checkOutput("idle rspValid", rspValid, 0);
    checkOutput("idle rdata", rspRdata, 0);
    checkOutput("idle err", rspErr, 0);
  endtask

  // Reference pick: pending requester at the smallest circular distance past the last served.
  function automatic int pickModel(input logic [NR-1:0] p, input int last);
    int best = -1;
    int bestDist = NR;
    for (int i = 0; i < NR; i++) begin
      if (p[i] && ((i - last - 1 + NR) % NR) < bestDist) begin
        bestDist = (i - last - 1 + NR) % NR;
        best = i;
      end
    end
    return best;
  endfunction

  initial begin
    vec_t vecs[6];
    int grants[$];
    int expOrder[4];
    int acc;
    bit done;
    logic [NR-1:0] pend, expOh;
    logic wrA[NR];
    logic [AW-1:0] adA[NR];
    logic [DW-1:0] wdA[NR];
    int last, owner, tAcc, waits, phase, d, pick, c;
    bit busy;
    logic mWrite, mErr;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mWdata, mPrdata;

    vecs[0] = '{0, 1'b0, 32'h1000, 32'h0,    0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1, 1'b1, 32'h2000, 32'h55,   3, 32'h12345678, 1'b0, 32'h0,        1'b0};
    vecs[2] = '{0, 1'b0, 32'h3004, 32'h0,    1, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b1};
    vecs[3] = '{1, 1'b1, 32'h4000, 32'hA5A5, 0, 32'h9999AAAA, 1'b1, 32'h0,        1'b1};
    vecs[4] = '{1, 1'b0, 32'h5008, 32'h0,    2, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 1'b0};
    vecs[5] = '{0, 1'b0, 32'h7000, 32'h0, TO-1, 32'h11223344, 1'b0, 32'h11223344, 1'b0};
    expOrder = '{0, 1, 0, 1};

    rst = 1'b1;
    clearInputs();
    #1;
    checkAllZero("reset");
    reqValid = '1;
    #1;
    checkOutput("reset ready masked", reqReady, 0);
    reqValid = '0;
    tick();
    rst = 1'b0;

    // Round-robin fairness with both requesters continuously valid.
    pready = 1'b1;
    for (int k = 0; k < 40 && grants.size() < 4; k++) begin
      tick();
      reqValid = '1;
      #1;
      if (reqReady == 2'b01) grants.push_back(0);
      else if (reqReady == 2'b10) grants.push_back(1);
      else if (reqReady != 2'b00) grants.push_back(9);
    end
    checkOutput("rr grant count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput("rr grant order", (grants.size() > i) ? grants[i] : 99, expOrder[i]);
    tick();
    reqValid = '0;
    pready = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    pready = 1'b1;
    tick(); tick(); tick(); tick();
    pready = 1'b0;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Single requester: grant is always index 0.
    for (int k = 0; k < 2; k++) begin
      tick();
      oneValid = 1'b1;
      oneAddr = 32'h100 + k;
      #1;
      checkOutput("nr1 ready", oneReady, 1);
      tick();
      oneValid = 1'b0;
      #1;
      checkOutput("nr1 paddr", onePsel ? onePaddr : 32'hFFFF_FFFF, 32'h100 + k);
      tick();
      tick();
      #1;
      checkOutput("nr1 rsp", oneRsp, 1);
      checkOutput("nr1 rdata", oneRdata, 32'hA5A5_0001);
      tick();
    end

    // Stalled slave: pready never arrives.
    tick();
    reqValid = 2'b01;
    reqWrite = '0;
    reqAddr[AW-1:0] = 32'h6000;
    #1;
    checkOutput("stall ready", reqReady, 2'b01);
    tick();
    reqValid = '0;
    acc = 0;
    done = 1'b0;
`ifdef ARA_APB_ARB_TIMEOUT_EN
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      pready = 1'b0; prdata = $urandom; pslverr = 1'b0;
      #1;
      if (penable) acc++;
      else if (acc > 0) begin
        done = 1'b1;
        checkOutput("timeout psel", psel, 0);
        checkOutput("timeout rsp", rspValid, 2'b01);
        checkOutput("timeout err", rspErr, 1);
        checkOutput("timeout rdata", rspRdata, 0);
      end
    end
    checkOutput("timeout access cycles", acc, TO);
    checkOutput("timeout resp seen", done, 1);
    tick();
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      pready = 1'b0; prdata = $urandom;
    end
    #1;
    checkOutput("no timeout psel", psel, 1);
    checkOutput("no timeout penable", penable, 1);
    tick();
    pready = 1'b1;
    tick();
    pready = 1'b0;
    #1;
    checkOutput("stall rsp", rspValid, 2'b01);
    tick();
`endif

    // Reset during ACCESS after requester 0 was last served.
    applyStimulus(vecs[0]);
    tick();
    reqValid = 2'b10;
    reqWrite = '0;
    reqAddr[AW +: AW] = 32'h8000;
    #1;
    checkOutput("rstacc ready", reqReady, 2'b10);
    tick();
    reqValid = '0;
    tick();
    #1;
    checkOutput("rstacc in access", penable, 1);
    reqValid = 2'b11;
    rst = 1'b1;
    #1;
    checkAllZero("rstacc");
    tick();
    #1;
    checkOutput("rstacc held ready", reqReady, 0);
    checkOutput("rstacc held rsp", rspValid, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rstacc first grant", reqReady, 2'b01);
    tick();
    reqValid = '0;
    pready = 1'b1;
    tick();
    tick();
    #1;
    checkOutput("rstacc rsp", rspValid, 2'b01);
    pready = 1'b0;

    // Randomized run against the timing/arbitration model.
    doReset();
    pend = '0; last = NR - 1; busy = 1'b0;
    owner = 0; tAcc = 0; waits = 0; c = 0;
    mWrite = 0; mErr = 0; mAddr = 0; mWdata = 0; mPrdata = 0;
    for (int i = 0; i < NR; i++) begin wrA[i] = 0; adA[i] = 0; wdA[i] = 0; end
    repeat (1500) begin
      tick();
      c++;
      d = c - tAcc;
      if (!busy) phase = 0;
      else if (d == 1) phase = 1;
      else if (d <= 2 + waits) phase = 2;
      else phase = 3;
      if (phase == 2) pready = (d == 2 + waits);
      else pready = 1'($urandom);
      prdata  = (phase == 2 && pready) ? mPrdata : $urandom;
      pslverr = (phase == 2 && pready) ? mErr : 1'($urandom);
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 35) begin
          pend[i] = 1'b1;
          wrA[i] = 1'($urandom); adA[i] = $urandom; wdA[i] = $urandom;
        end
        reqWrite[i] = pend[i] ? wrA[i] : 1'($urandom);
        reqAddr[i*AW +: AW] = pend[i] ? adA[i] : $urandom;
        reqWdata[i*DW +: DW] = pend[i] ? wdA[i] : $urandom;
      end
      reqValid = pend;
      #1;
      pick = (phase == 0) ? pickModel(pend, last) : -1;
      expOh = '0;
      if (pick >= 0) expOh[pick] = 1'b1;
      checkOutput("rand ready", reqReady, expOh);
      checkOutput("rand psel", psel, phase == 1 || phase == 2);
      checkOutput("rand penable", penable, phase == 2);
      checkOutput("rand pwrite", pwrite, (phase == 1 || phase == 2) ? mWrite : 1'b0);
      checkOutput("rand paddr", paddr, (phase == 1 || phase == 2) ? mAddr : '0);
      checkOutput("rand pwdata", pwdata, (phase == 1 || phase == 2) ? mWdata : '0);
      expOh = '0;
      if (phase == 3) expOh[owner] = 1'b1;
      checkOutput("rand rspValid", rspValid, expOh);
      checkOutput("rand rdata", rspRdata, (phase == 3 && !mWrite) ? mPrdata : '0);
      checkOutput("rand err", rspErr, (phase == 3) ? mErr : 1'b0);
      if (phase == 3) begin
        busy = 1'b0;
        last = owner;
      end
      if (pick >= 0) begin
        busy = 1'b1; owner = pick; tAcc = c; waits = $urandom_range(0, 3);
        mWrite = wrA[pick]; mAddr = adA[pick]; mWdata = wdA[pick];
        mPrdata = $urandom; mErr = ($urandom_range(0, 3) == 0);
        pend[pick] = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
